// File: rtl/pim_axi_loader.sv
// Single-outstanding AXI4 INCR burst master that loads/reads PIM weight rows.
// Data channels pass straight through in WDATA/RDATA; local beat counter frames wlast/rd_last.
module pim_axi_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,

  output logic                  busy,
  output logic                  resp_err,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  bready_q;
  logic                  err_q;

  logic in_wdata;
  logic in_rdata;
  logic last_beat;
  logic w_hs;
  logic r_hs;

  assign in_wdata  = (state == WDATA);
  assign in_rdata  = (state == RDATA);
  assign last_beat = (beat_cnt == 8'd0);
  assign w_hs      = in_wdata & wr_valid & m_axi_wready;
  assign r_hs      = in_rdata & m_axi_rvalid & rd_ready;

  // Framing comes from our own counter, so the slave's rlast and the IDs are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= cmd_len;
            if (cmd_write) begin
              state     <= WADDR;
              awvalid_q <= 1'b1;
            end else begin
              state     <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= WDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (last_beat) begin
              state    <= WRESP;
              bready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            state    <= IDLE;
            if (m_axi_bresp != 2'b00) err_q <= 1'b1;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (m_axi_rresp != 2'b00) err_q <= 1'b1;
            if (last_beat) state <= IDLE;
            else           beat_cnt <= beat_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign resp_err  = err_q;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = in_wdata & last_beat;
  assign m_axi_wvalid = in_wdata & wr_valid;
  assign wr_ready     = in_wdata & m_axi_wready;

  assign m_axi_bready = bready_q;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = in_rdata & m_axi_rvalid;
  assign rd_last      = in_rdata & last_beat;
  assign m_axi_rready = in_rdata & rd_ready;

endmodule

// File: tb/tb_pim_axi_loader.sv
// Directed bench: host-side command/data driver plus a small AXI slave memory model.
module tb_pim_axi_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic        busy, resp_err;
  logic [7:0]  m_axi_awid, m_axi_awaddr, m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [7:0]  m_axi_arid, m_axi_araddr, m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  pim_axi_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .resp_err(resp_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  bit          rst_k;
  bit          cmd_pend;
  bit          cmd_w;
  logic [7:0]  cmd_a, cmd_l;
  logic [31:0] wq[$];
  int          awr_pct = 100, wr_pct = 100, arr_pct = 100;
  logic [15:0] rd_pat = 16'hFFFF;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;

  // slave model and observation logs
  logic [31:0] mem [0:63];
  bit          aw_seen, b_pend, r_act;
  logic [5:0]  w_ptr, r_ptr;
  logic [7:0]  r_left;
  int          aw_cnt, ar_cnt;
  logic [7:0]  aw_addr_c, aw_len_c, ar_addr_c, ar_len_c;
  logic [2:0]  aw_size_c, ar_size_c;
  logic [1:0]  aw_burst_c, ar_burst_c;
  logic [31:0] wlog[$];
  bit          wlast_log[$];
  logic [31:0] rx[$];
  bit          rxl[$];
  int          busy_cnt;
  int          stall_viol, strb_bad;
  bit          aw_stall, ar_stall, rd_stall;
  logic [7:0]  aw_hold, ar_hold;
  logic [31:0] rd_hold;

  task automatic tick();
    @(negedge clk);
    rst           = rst_k;
    cmd_valid     = cmd_pend;
    cmd_write     = cmd_w;
    cmd_addr      = cmd_a;
    cmd_len       = cmd_l;
    wr_valid      = (wq.size() != 0);
    wr_data       = wr_valid ? wq[0] : 32'hDEAD_BEEF;
    rd_ready      = rd_pat[0];
    rd_pat        = {rd_pat[0], rd_pat[15:1]};
    m_axi_awready = ($urandom_range(0, 99) < awr_pct);
    m_axi_wready  = aw_seen && ($urandom_range(0, 99) < wr_pct);
    m_axi_bvalid  = b_pend;
    m_axi_bresp   = bresp_k;
    m_axi_arready = ($urandom_range(0, 99) < arr_pct);
    m_axi_rvalid  = r_act;
    m_axi_rdata   = r_act ? mem[r_ptr] : 32'h0;
    m_axi_rresp   = rresp_k;
    m_axi_rlast   = r_act && (r_left == 8'd0);
    #1;
    if (rst_k) begin
      aw_seen = 0; b_pend = 0; r_act = 0; cmd_pend = 0;
      aw_stall = 0; ar_stall = 0; rd_stall = 0;
      return;
    end
    if (busy) busy_cnt++;
    if (aw_stall && !(m_axi_awvalid && m_axi_awaddr == aw_hold)) stall_viol++;
    if (ar_stall && !(m_axi_arvalid && m_axi_araddr == ar_hold)) stall_viol++;
    if (rd_stall && !(rd_valid && rd_data == rd_hold)) stall_viol++;
    aw_stall = m_axi_awvalid && !m_axi_awready; aw_hold = m_axi_awaddr;
    ar_stall = m_axi_arvalid && !m_axi_arready; ar_hold = m_axi_araddr;
    rd_stall = rd_valid && !rd_ready;           rd_hold = rd_data;
    if (m_axi_wvalid && m_axi_wstrb != 4'hF) strb_bad++;

    if (cmd_valid && cmd_ready) cmd_pend = 0;
    if (m_axi_bvalid && m_axi_bready) b_pend = 0;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_seen = 1; aw_cnt++;
      aw_addr_c = m_axi_awaddr; aw_len_c = m_axi_awlen;
      aw_size_c = m_axi_awsize; aw_burst_c = m_axi_awburst;
      w_ptr = m_axi_awaddr[7:2];
    end
    if (m_axi_wvalid && m_axi_wready) begin
      wlog.push_back(m_axi_wdata);
      wlast_log.push_back(m_axi_wlast);
      mem[w_ptr] = m_axi_wdata;
      w_ptr = w_ptr + 6'd1;
      if (m_axi_wlast) begin b_pend = 1; aw_seen = 0; end
    end
    if (wr_valid && wr_ready) void'(wq.pop_front());
    if (rd_valid && rd_ready) begin rx.push_back(rd_data); rxl.push_back(rd_last); end
    if (m_axi_rvalid && m_axi_rready) begin
      if (r_left == 8'd0) r_act = 0;
      else begin r_left = r_left - 8'd1; r_ptr = r_ptr + 6'd1; end
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_cnt++; r_act = 1;
      ar_addr_c = m_axi_araddr; ar_len_c = m_axi_arlen;
      ar_size_c = m_axi_arsize; ar_burst_c = m_axi_arburst;
      r_ptr = m_axi_araddr[7:2]; r_left = m_axi_arlen;
    end
  endtask

  // Issue one command and run until the loader returns to idle.
  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] l, input string tag);
    int t;
    cmd_w = w; cmd_a = a; cmd_l = l; cmd_pend = 1;
    aw_cnt = 0; ar_cnt = 0;
    wlog.delete(); wlast_log.delete(); rx.delete(); rxl.delete();
    t = 0;
    do begin tick(); t++; end while (cmd_pend && t < 100);
    busy_cnt = 0;
    t = 0;
    do begin tick(); t++; end while (busy && t < 400);
    check({tag, "_timeout"}, 32'(t >= 400), 0);
  endtask

  task automatic check_words(input string tag, input logic [31:0] got[$], input logic [31:0] base, input int n);
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got[i], base + 32'(i));
  endtask

  function automatic logic [31:0] pack_bits(input bit b[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < b.size() && i < 32; i++) v[i] = b[i];
    return v;
  endfunction

  initial begin
    int t;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rvalid = 0;

    rst_k = 1;
    repeat (3) tick();
    check("rst_busy",     32'(busy), 0);
    check("rst_cmd_rdy",  32'(cmd_ready), 1);
    check("rst_awvalid",  32'(m_axi_awvalid), 0);
    check("rst_arvalid",  32'(m_axi_arvalid), 0);
    check("rst_bready",   32'(m_axi_bready), 0);
    check("rst_wvalid",   32'(m_axi_wvalid), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    rst_k = 0;
    tick();

    // Zero-wait write of 4 beats: AW + 4 W + B = 6 busy cycles.
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    issue(1, 8'h10, 8'd3, "wr1");
    check("wr1_aw_cnt",  32'(aw_cnt), 1);
    check("wr1_awaddr",  32'(aw_addr_c), 32'h10);
    check("wr1_awlen",   32'(aw_len_c), 3);
    check("wr1_awsize",  32'(aw_size_c), 2);
    check("wr1_awburst", 32'(aw_burst_c), 1);
    check_words("wr1_w", wlog, 32'hA0, 4);
    check("wr1_wlast",    pack_bits(wlast_log), 32'b1000);
    check("wr1_busy_cyc", 32'(busy_cnt), 6);
    check("wr1_busy",     32'(busy), 0);
    check("wr1_mem7",     mem[7], 32'hA3);

    // Zero-wait read back: AR + 4 R = 5 busy cycles.
    issue(0, 8'h10, 8'd3, "rd1");
    check("rd1_ar_cnt",  32'(ar_cnt), 1);
    check("rd1_araddr",  32'(ar_addr_c), 32'h10);
    check("rd1_arlen",   32'(ar_len_c), 3);
    check("rd1_arsize",  32'(ar_size_c), 2);
    check("rd1_arburst", 32'(ar_burst_c), 1);
    check_words("rd1_r", rx, 32'hA0, 4);
    check("rd1_last",     pack_bits(rxl), 32'b1000);
    check("rd1_busy_cyc", 32'(busy_cnt), 5);

    // Backpressure on every channel.
    awr_pct = 40; wr_pct = 55; arr_pct = 40;
    wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    issue(1, 8'h20, 8'd5, "wr2");
    check_words("wr2_w", wlog, 32'hB0, 6);
    check("wr2_wlast", pack_bits(wlast_log), 32'b10_0000);
    check("wr2_mem13", mem[13], 32'hB5);
    rd_pat = 16'b1011_0010_1101_0011;
    issue(0, 8'h20, 8'd5, "rd2");
    check_words("rd2_r", rx, 32'hB0, 6);
    check("rd2_last",   pack_bits(rxl), 32'b10_0000);
    check("stall_viol", 32'(stall_viol), 0);
    check("wstrb_bad",  32'(strb_bad), 0);
    awr_pct = 100; wr_pct = 100; arr_pct = 100; rd_pat = 16'hFFFF;

    // Single-beat write answered with SLVERR.
    bresp_k = 2'b10;
    wq = '{32'h1234_5678};
    issue(1, 8'h30, 8'd0, "wr3");
    check("wr3_busy_cyc", 32'(busy_cnt), 3);
    check("wr3_cmd_rdy",  32'(cmd_ready), 1);
    check("wr3_beats",    32'(wlog.size()), 1);
    check("wr3_wlast",    pack_bits(wlast_log), 32'b1);
    check("wr3_data",     mem[12], 32'h1234_5678);
    check("wr3_resp_err", 32'(resp_err), 1);
    bresp_k = 2'b00;
    issue(0, 8'h30, 8'd0, "rd3");
    check_words("rd3_r", rx, 32'h1234_5678, 1);
    check("rd3_last",     pack_bits(rxl), 32'b1);
    check("rd3_resp_err", 32'(resp_err), 1);
    rst_k = 1; tick(); rst_k = 0; tick();
    check("err_clr", 32'(resp_err), 0);

    // Reset in the middle of a write burst after two of four beats.
    wq = '{32'hC0, 32'hC1};
    cmd_w = 1; cmd_a = 8'h00; cmd_l = 8'd3; cmd_pend = 1;
    wlog.delete(); wlast_log.delete();
    t = 0;
    do begin tick(); t++; end while (wlog.size() < 2 && t < 100);
    check("mid_timeout", 32'(t >= 100), 0);
    wq.push_back(32'hC2);
    rst_k = 1; tick(); rst_k = 0; tick();
    check("mid_busy",    32'(busy), 0);
    check("mid_wvalid",  32'(m_axi_wvalid), 0);
    check("mid_cmd_rdy", 32'(cmd_ready), 1);
    check("mid_bready",  32'(m_axi_bready), 0);
    wq.delete();
    tick();

    // Read error response also sets the sticky flag.
    rresp_k = 2'b10;
    issue(0, 8'h10, 8'd1, "rd4");
    check_words("rd4_r", rx, 32'hA0, 2);
    check("rd4_resp_err", 32'(resp_err), 1);
    rresp_k = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pim_axi_loader.md
Name: pim_axi_loader

Overview:
- AXI4 burst master that sits directly upstream of the AXI PIM slave and drives its s_axi_* port.
- Accepts simple write or read commands from a host or controller.
- For writes, streams data words into INCR write bursts that load PIM weight rows.
- For reads, issues read bursts and returns the words on a ready/valid output stream. Supplies the wlast framing the PIM slave requires.

Parameters:
DATA_WIDTH, 32, AXI data width in bits
ADDR_WIDTH, 8, AXI byte address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
ID_WIDTH, 8, AXI ID width
AXI_ID, 0, constant ID driven on awid/arid

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid/cmd_ready  input/output  1/1  command handshake
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_WIDTH  start byte address
cmd_len  input  8  beats minus 1 (AXI len encoding)
wr_data/wr_valid/wr_ready  input/input/output  DATA_WIDTH/1/1  write data stream
rd_data/rd_valid/rd_ready/rd_last  output/output/input/output  DATA_WIDTH/1/1/1  read data stream
busy  output  1  high whenever state != IDLE
resp_err  output  1  sticky; set on any nonzero bresp/rresp
m_axi_aw{id,addr,len,size,burst,valid}/awready  out/in  ID_WIDTH,ADDR_WIDTH,8,3,2,1/1  write address channel
m_axi_w{data,strb,last,valid}/wready  out/in  DATA_WIDTH,STRB_WIDTH,1,1/1  write data channel
m_axi_b{id,resp,valid}/bready  in/out  ID_WIDTH,2,1/1  write response channel
m_axi_ar{id,addr,len,size,burst,valid}/arready  out/in  same widths as AW  read address channel
m_axi_r{id,data,resp,last,valid}/rready  in/out  ID_WIDTH,DATA_WIDTH,2,1,1/1  read data channel

Behaviour:
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA. Reset (rst=1 at clk edge) forces IDLE from any state, including mid-burst.
- Reset values: all valid outputs 0, busy 0, resp_err 0, beat counter 0. No AXI transaction is completed after reset; the downstream slave must also be reset.
- cmd_ready = (state == IDLE). On cmd_valid & cmd_ready:
  - Latch addr and len; beat counter = cmd_len.
  - cmd_write=1 -> WADDR; cmd_write=0 -> RADDR.
- Constant AXI fields: awsize/arsize = log2(STRB_WIDTH); awburst/arburst = 2'b01 (INCR); wstrb all ones; awid/arid = AXI_ID; awaddr/araddr = latched addr; awlen/arlen = latched len.
- WADDR: awvalid=1 registered. On awready -> WDATA. Address is issued before any W beat.
- WDATA:
  - Combinational pass-through: wvalid = wr_valid, wr_ready = wready, wdata = wr_data.
  - wlast = (counter == 0).
  - Each wvalid & wready decrements the counter; the beat with wlast -> WRESP.
  - Exactly cmd_len+1 beats are accepted.
- WRESP: bready=1. On bvalid -> IDLE; if bresp != 0, set resp_err.
- RADDR: arvalid=1. On arready -> RDATA.
- RDATA:
  - Pass-through: rd_valid = rvalid, rready = rd_ready, rd_data = rdata.
  - rd_last = (counter == 0), generated locally; m_axi_rlast is ignored for framing.
  - Each handshake decrements the counter; the final beat (counter == 0) -> IDLE.
  - rresp != 0 on any beat sets resp_err.
- Valids, once asserted, hold until their handshake completes; payload is stable while valid is low-ready.
- Cycle counts with zero-wait slave: len=0 write takes 3 cycles from cmd handshake to IDLE (AW, W, B). Back-to-back commands have 1 IDLE cycle between them.
- Address increment and 4KB boundaries are the slave's concern. cmd_addr+len overflowing ADDR_WIDTH is not checked.
- resp_err clears only on rst.
- No outstanding transactions: one command in flight.

Test Plan:
- Write cmd addr=0x10, len=3, data 0xA0..0xA3 -> one AW (awaddr=0x10, awlen=3, awsize=2, awburst=1); 4 W beats with wlast only on 0xA3; bready until bvalid; busy low after.
- Read cmd addr=0x10, len=3 after the write -> AR (araddr=0x10, arlen=3); rd_data 0xA0..0xA3; rd_last on 4th beat only.
- Backpressure: random wready/awready gaps and rd_ready toggling 1-0-1 -> no beat lost or duplicated; valids hold stable; payload unchanged while stalled.
- len=0 write of 0x12345678 -> single W beat with wlast=1; cmd_ready returns 1 cycle after bvalid handshake.
- Slave returns bresp=2'b10 -> resp_err=1 and stays 1 through a following clean read; cleared only by rst.
- rst asserted during WDATA after 2 of 4 beats -> next cycle state IDLE, wvalid=0, busy=0, cmd_ready=1.
